// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-register state encoding and per-stage bundle constants
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  localparam int IF_ID_W = 33;
  localparam logic [IF_ID_W-1:0] IF_ID_KEEP = {32'hFFFF_FFFF, 1'b0};
  localparam int ID_EX_W = 48;
  localparam logic [ID_EX_W-1:0] ID_EX_KEEP = {2'b11, 46'd0};
endpackage

// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: valid/ready/data bundle link between two stages
interface pipe_stage_skid_if #(parameter int DATA_W = 16);
  logic valid;
  logic ready;
  logic [DATA_W-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear taking priority
module sat_counter #(parameter int CNT_W = 16) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with 2-entry skid, bubble-inserting flush
// and a saturating backpressure counter
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter logic [DATA_W-1:0] KEEP_MASK = '0,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic clr_stats,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
  output logic [1:0] occupancy,
  output logic [CNT_W-1:0] stall_cycles
);
  state_t state, state_n;
  logic [DATA_W-1:0] main_q, main_n, skid_q, skid_n;
  logic in_fire, out_fire;
  // handshake outputs decode only the state register, so ready never depends on out_ready
  assign up.ready  = state != TWO;
  assign dn.valid  = state != EMPTY;
  assign dn.data   = main_q;
  assign occupancy = state;
  assign in_fire   = up.valid & up.ready;
  assign out_fire  = dn.valid & dn.ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = EMPTY;
      main_n  = (up.data & KEEP_MASK) | (NOP_VALUE & ~KEEP_MASK);
      skid_n  = NOP_VALUE;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          state_n = ONE;
          main_n  = up.data;
        end
        ONE: if (in_fire && out_fire) main_n = up.data;
        else if (in_fire) begin
          state_n = TWO;
          skid_n  = up.data;
        end else if (out_fire) begin
          state_n = EMPTY;
          main_n  = NOP_VALUE;
        end
        TWO: if (out_fire) begin
          state_n = ONE;
          main_n  = skid_q;
          skid_n  = NOP_VALUE;
        end
        default: state_n = EMPTY;
      endcase
    end
  end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk),
    .rst_n(rst_n),
    .inc(dn.valid & ~dn.ready),
    .clr(clr_stats),
    .cnt(stall_cycles)
  );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed scenario tasks plus a queue-model random stress for pipe_stage_skid
module tb_pipe_stage_skid;
  logic clk = 0, rst_n = 1, flush = 0, clr_stats = 0;
  logic [1:0] occupancy;
  logic [3:0] stall_cycles;
  int errors = 0, checks = 0;
  pipe_stage_skid_if #(.DATA_W(16)) up ();
  pipe_stage_skid_if #(.DATA_W(16)) dn ();
  pipe_stage_skid #(.DATA_W(16), .NOP_VALUE(16'h0000), .KEEP_MASK(16'hFF00), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .clr_stats(clr_stats),
    .up(up), .dn(dn), .occupancy(occupancy), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    up.valid = 0; up.data = '0; dn.ready = 0;
    #1 rst_n = 0;
    step();
    step();
    checks++;
    if ({dn.valid, up.ready, occupancy, stall_cycles, dn.data} !== {1'b0, 1'b1, 2'd0, 4'd0, 16'h0000}) begin
      errors++;
      $display("FAIL reset: v/rdy/occ/stall/data=%b/%b/%0d/%0d/%h want 0/1/0/0/0000", dn.valid, up.ready, occupancy, stall_cycles, dn.data);
    end
    rst_n = 1;
    step();
    checks++;
    if ({dn.valid, up.ready, occupancy} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL reset_release: v/rdy/occ=%b/%b/%0d want 0/1/0", dn.valid, up.ready, occupancy);
    end
  endtask

  task automatic test_throughput();
    dn.ready = 1;
    for (int i = 1; i <= 16; i++) begin
      up.valid = 1; up.data = 16'(i);
      step();
      checks++;
      if ({dn.valid, up.ready, occupancy, dn.data} !== {1'b1, 1'b1, 2'd1, 16'(i)}) begin
        errors++;
        $display("FAIL throughput[%0d]: v/rdy/occ/data=%b/%b/%0d/%h want 1/1/1/%h", i, dn.valid, up.ready, occupancy, dn.data, 16'(i));
      end
    end
    up.valid = 0;
    step();
    checks++;
    if ({dn.valid, occupancy} !== {1'b0, 2'd0}) begin
      errors++;
      $display("FAIL throughput_drain: v/occ=%b/%0d want 0/0", dn.valid, occupancy);
    end
  endtask

  task automatic test_skid_fill();
    logic [15:0] exp_d[4] = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hBBBB};
    logic [1:0]  exp_o[4] = '{2'd1, 2'd2, 2'd2, 2'd1};
    logic        exp_r[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0]  exp_s[4] = '{4'd0, 4'd1, 4'd2, 4'd2};
    clr_stats = 1; dn.ready = 0;
    step();
    clr_stats = 0;
    for (int i = 0; i < 4; i++) begin
      up.valid = i < 2;
      up.data  = i == 0 ? 16'hAAAA : 16'hBBBB;
      dn.ready = i == 3;
      step();
      checks++;
      if ({dn.valid, up.ready, occupancy, stall_cycles, dn.data} !== {1'b1, exp_r[i], exp_o[i], exp_s[i], exp_d[i]}) begin
        errors++;
        $display("FAIL skid[%0d]: v/rdy/occ/stall/data=%b/%b/%0d/%0d/%h want 1/%b/%0d/%0d/%h",
                 i, dn.valid, up.ready, occupancy, stall_cycles, dn.data, exp_r[i], exp_o[i], exp_s[i], exp_d[i]);
      end
    end
    up.valid = 0;
    step();
    checks++;
    if ({dn.valid, up.ready, occupancy} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL skid_drain: v/rdy/occ=%b/%b/%0d want 0/1/0", dn.valid, up.ready, occupancy);
    end
  endtask

  task automatic test_flush();
    dn.ready = 0; up.valid = 1;
    up.data = 16'h1111; step();
    up.data = 16'h2222; step();
    checks++;
    if ({occupancy, up.ready} !== {2'd2, 1'b0}) begin
      errors++;
      $display("FAIL flush_setup: occ/rdy=%0d/%b want 2/0", occupancy, up.ready);
    end
    flush = 1; up.data = 16'h12CD;
    step();
    flush = 0; up.valid = 0;
    checks++;
    if ({dn.valid, up.ready, occupancy, dn.data} !== {1'b0, 1'b1, 2'd0, 16'h1200}) begin
      errors++;
      $display("FAIL flush_bubble: v/rdy/occ/data=%b/%b/%0d/%h want 0/1/0/1200", dn.valid, up.ready, occupancy, dn.data);
    end
    dn.ready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({dn.valid, dn.data} !== {1'b0, 16'h1200}) begin
        errors++;
        $display("FAIL flush_no_leak[%0d]: v/data=%b/%h want 0/1200", i, dn.valid, dn.data);
      end
    end
  endtask

  task automatic test_saturation();
    dn.ready = 0; up.valid = 1; up.data = 16'h0042; clr_stats = 1;
    step();
    up.valid = 0; clr_stats = 0;
    checks++;
    if ({stall_cycles, occupancy} !== {4'd0, 2'd1}) begin
      errors++;
      $display("FAIL sat_start: stall/occ=%0d/%0d want 0/1", stall_cycles, occupancy);
    end
    repeat (20) step();
    checks++;
    if (stall_cycles !== 4'd15) begin
      errors++;
      $display("FAIL sat_20: stall=%0d want 15", stall_cycles);
    end
    step();
    checks++;
    if (stall_cycles !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: stall=%0d want 15", stall_cycles);
    end
    clr_stats = 1;
    step();
    clr_stats = 0;
    checks++;
    if (stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL sat_clear: stall=%0d want 0", stall_cycles);
    end
    step();
    checks++;
    if (stall_cycles !== 4'd1) begin
      errors++;
      $display("FAIL sat_restart: stall=%0d want 1", stall_cycles);
    end
    dn.ready = 1;
    step();
  endtask

  task automatic test_async_reset();
    dn.ready = 0; up.valid = 1;
    up.data = 16'h3333; step();
    up.data = 16'h4444; step();
    up.valid = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({dn.valid, up.ready, occupancy, stall_cycles, dn.data} !== {1'b0, 1'b1, 2'd0, 4'd0, 16'h0000}) begin
      errors++;
      $display("FAIL async_reset: v/rdy/occ/stall/data=%b/%b/%0d/%0d/%h want 0/1/0/0/0000", dn.valid, up.ready, occupancy, stall_cycles, dn.data);
    end
    step();
    rst_n = 1; dn.ready = 1; up.valid = 1; up.data = 16'h5555;
    step();
    up.valid = 0;
    checks++;
    if ({dn.valid, dn.data} !== {1'b1, 16'h5555}) begin
      errors++;
      $display("FAIL async_resend: v/data=%b/%h want 1/5555", dn.valid, dn.data);
    end
    step();
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    logic fi, fo;
    for (int c = 0; c < 2000; c++) begin
      up.valid = 1'($urandom_range(0, 1));
      dn.ready = 1'($urandom_range(0, 1));
      flush    = $urandom_range(0, 15) == 0;
      up.data  = 16'($urandom);
      fi = up.valid && q.size() < 2;
      fo = dn.ready && q.size() > 0;
      if (flush) q.delete();
      else begin
        if (fo) void'(q.pop_front());
        if (fi) q.push_back(up.data);
      end
      step();
      checks++;
      if ({dn.valid, up.ready, occupancy} !== {q.size() != 0, q.size() < 2, 2'(q.size())}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: v/rdy/occ=%b/%b/%0d want occ %0d", c, dn.valid, up.ready, occupancy, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (dn.data !== q[0]) begin
          errors++;
          $display("FAIL rand_data[%0d]: data=%h want %h", c, dn.data, q[0]);
        end
      end
    end
    flush = 0; up.valid = 0;
  endtask

  initial begin
    test_reset();
    test_throughput();
    test_skid_fill();
    test_flush();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
